dbg_switch_debounce: RTL and testbench
======================================

Name: dbg_switch_debounce

Overview:
Conditions the raw board debug switches (pin_dbg_switch_i[8:5]) before the top level uses them for video_uut switch inputs and LED source selection.
- Synchronises each asynchronous, active-low pin into clk_25m.
- Debounces each channel with a stability counter.
- Outputs clean active-high levels, one-cycle press/release pulses and a per-switch toggle state.
- Sits between the switch pins and all switch consumers in the top level.

Parameters:
NUM_SW, 4, number of switch channels.
DEBOUNCE_CYCLES, 250_000, consecutive stable clk_25m cycles required to accept a new level (10 ms at 25 MHz); legal range is ≥2.
SYNC_STAGES, 2, synchroniser flops per channel; legal range is ≥2.
ACTIVE_LOW, 1, 1 means a pin at 0 is "pressed"; 0 means a pin at 1 is "pressed".

Ports:
clk_25m  input  1  free-running 25 MHz reference clock.
rst_in  input  1  reset, asynchronous, active-high (clk_25m domain).
sw_i  input  NUM_SW  raw switch pins, asynchronous to clk_25m.
sw_level_o  output  NUM_SW  debounced level, 1 = pressed.
sw_press_p_o  output  NUM_SW  one-cycle pulse when sw_level_o rises.
sw_release_p_o  output  NUM_SW  one-cycle pulse when sw_level_o falls.
sw_toggle_o  output  NUM_SW  flips on every press pulse.
stable_o  output  1  1 when no channel has a non-zero debounce counter.

Behaviour:
- Reset values (rst_in asserted, asynchronous):
  - synchroniser flops = inactive pin level (1 when ACTIVE_LOW = 1);
  - sw_level_o = 0, sw_toggle_o = 0, press/release pulses = 0;
  - all counters = 0; stable_o = 1.
- Synchroniser: SYNC_STAGES flops with the ASYNC_REG attribute. Its output is normalised to active-high as sync_n = sync XOR ACTIVE_LOW.
- Counter: per channel, width $clog2(DEBOUNCE_CYCLES).
  - sync_n == sw_level_o: counter cleared to 0.
  - sync_n != sw_level_o and counter < DEBOUNCE_CYCLES-1: counter increments.
  - sync_n != sw_level_o and counter == DEBOUNCE_CYCLES-1: sw_level_o <= sync_n, counter <= 0, and the matching pulse is asserted for exactly that one registered cycle.
- Net effect: sw_level_o changes on the DEBOUNCE_CYCLES-th consecutive edge at which sync_n differs from it.
- Latency: from the first clk_25m edge that samples a new stable pin value to the sw_level_o change is SYNC_STAGES + DEBOUNCE_CYCLES edges.
- Glitch rejection: any return of sync_n to the current level before the count completes clears the counter. Nothing changes and no pulse is produced.
- No wrap: the counter never exceeds DEBOUNCE_CYCLES-1.
- Pulse and toggle timing:
  - press_p and release_p are registered, coincident with the sw_level_o edge, and mutually exclusive per channel.
  - sw_toggle_o flips in the cycle after press_p is asserted (registered from press_p). It does not change on release.
- stable_o is a registered NOR of all (counter != 0); it lags the counters by one cycle.
- Channels are fully independent. Simultaneous transitions on several channels each produce their own pulse in the same cycle.
- Reset mid-count: the pending transition is discarded and outputs return to reset values. After reset release, a pin held pressed is re-qualified over the full latency, which produces a press pulse.
- Pin held in one state indefinitely: no pulses, counter stays 0.

Decomposition:
- Package dbg_pkg:
  - CLK_25M_HZ = 25_000_000;
  - DEBOUNCE_10MS = CLK_25M_HZ/100;
  - function cnt_width(n) returning $clog2(n).
- Sub-module dbg_debounce_ch: one channel (synchroniser, counter, level, press/release pulses, toggle), instantiated NUM_SW times in a generate loop. The top computes stable_o.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=8, SYNC_STAGES=2, ACTIVE_LOW=1, NUM_SW=4.
1. Reset / idle: hold sw_i=4'b1111, pulse rst_in, run 50 cycles -> sw_level_o=0, no pulses, sw_toggle_o=0, stable_o=1 throughout.
2. Clean press: drive sw_i[0]=0 just before edge 0 and hold -> sw_level_o[0]=1 and sw_press_p_o[0]=1 at edge 10 only; sw_toggle_o[0]=1 from edge 11. Repeat with a release -> sw_release_p_o[0] pulses once at edge 10 and the toggle is unchanged.
3. Glitch: drive sw_i[1]=0 for 7 cycles then 1 -> no level change, no pulse, stable_o returns to 1. Repeat with 8+ cycles -> a single press pulse.
4. Bounce: toggle sw_i[2] every 3 cycles for 30 cycles, then hold 0 -> exactly one press pulse, 10 edges after the final hold begins.
5. Simultaneous: drive sw_i[3:0]=4'b0000 at once -> all four press pulses in the same cycle and sw_toggle_o=4'b1111 one cycle later.
6. Reset mid-count: hold sw_i[0]=0 for 6 cycles, assert rst_in for 1 cycle while keeping sw_i[0]=0 -> outputs reset immediately; a press pulse occurs 10 edges after rst_in deasserts.

Source files
------------

// File: rtl/dbg_switch_debounce_pkg.sv
// Shared constants and helpers for the debug-switch conditioning block.
// Default debounce window is 10 ms of the 25 MHz board clock.
package dbg_pkg;

  localparam int CLK_25M_HZ    = 25_000_000;
  localparam int DEBOUNCE_10MS = CLK_25M_HZ / 100;

  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/dbg_switch_debounce_if.sv
// Conditioned switch outputs as seen by the top-level consumers.
// The debouncer drives the master side and consumers read the slave side.
interface dbg_switch_debounce_if #(
  parameter int NUM_SW = 4
);

  logic [NUM_SW-1:0] sw_level_o;
  logic [NUM_SW-1:0] sw_press_p_o;
  logic [NUM_SW-1:0] sw_release_p_o;
  logic [NUM_SW-1:0] sw_toggle_o;
  logic              stable_o;

  modport master (
    output sw_level_o,
    output sw_press_p_o,
    output sw_release_p_o,
    output sw_toggle_o,
    output stable_o
  );

  modport slave (
    input sw_level_o,
    input sw_press_p_o,
    input sw_release_p_o,
    input sw_toggle_o,
    input stable_o
  );

endinterface

// File: rtl/dbg_switch_debounce_ch.sv
// One switch channel: synchroniser, stability counter, level,
// press/release pulses and toggle state.
module dbg_debounce_ch
  import dbg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int SYNC_STAGES     = 2,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk_25m,
  input  logic rst_in,
  input  logic sw_i,
  output logic level_o,
  output logic press_p_o,
  output logic release_p_o,
  output logic toggle_o,
  output logic busy_o
);

  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic           INACTIVE = (ACTIVE_LOW != 0);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

  logic          sync_n;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          toggle_q, toggle_d;

  always_ff @(posedge clk_25m or posedge rst_in) begin
    if (rst_in) begin
      sync_q <= {SYNC_STAGES{INACTIVE}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_i};
    end
  end

  // Normalise to 1 = pressed regardless of pin polarity.
  assign sync_n = sync_q[SYNC_STAGES-1] ^ INACTIVE;

  always_comb begin
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    toggle_d  = toggle_q ^ press_q;
    if (sync_n == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d   = sync_n;
      cnt_d     = '0;
      press_d   = sync_n;
      release_d = ~sync_n;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_25m or posedge rst_in) begin
    if (rst_in) begin
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      toggle_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
    end
  end

  assign level_o     = level_q;
  assign press_p_o   = press_q;
  assign release_p_o = release_q;
  assign toggle_o    = toggle_q;
  assign busy_o      = (cnt_q != '0);

endmodule

// File: rtl/dbg_switch_debounce.sv
// Debug-switch conditioning: NUM_SW independent debounce channels plus a
// registered "all quiet" flag for consumers that want to wait for settling.
module dbg_switch_debounce
  import dbg_pkg::*;
#(
  parameter int NUM_SW          = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int SYNC_STAGES     = 2,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                  clk_25m,
  input  logic                  rst_in,
  input  logic [NUM_SW-1:0]     sw_i,
  dbg_switch_debounce_if.master sw_if
);

  logic [NUM_SW-1:0] level_w;
  logic [NUM_SW-1:0] press_w;
  logic [NUM_SW-1:0] release_w;
  logic [NUM_SW-1:0] toggle_w;
  logic [NUM_SW-1:0] busy_w;
  logic              stable_q, stable_d;

  generate
    for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_ch
      dbg_debounce_ch #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES),
        .ACTIVE_LOW     (ACTIVE_LOW)
      ) u_ch (
        .clk_25m    (clk_25m),
        .rst_in     (rst_in),
        .sw_i       (sw_i[gi]),
        .level_o    (level_w[gi]),
        .press_p_o  (press_w[gi]),
        .release_p_o(release_w[gi]),
        .toggle_o   (toggle_w[gi]),
        .busy_o     (busy_w[gi])
      );
    end
  endgenerate

  assign stable_d = ~|busy_w;

  always_ff @(posedge clk_25m or posedge rst_in) begin
    if (rst_in) begin
      stable_q <= 1'b1;
    end else begin
      stable_q <= stable_d;
    end
  end

  assign sw_if.sw_level_o     = level_w;
  assign sw_if.sw_press_p_o   = press_w;
  assign sw_if.sw_release_p_o = release_w;
  assign sw_if.sw_toggle_o    = toggle_w;
  assign sw_if.stable_o       = stable_q;

endmodule

// File: tb/tb_dbg_switch_debounce.sv
// Scenario bench for dbg_switch_debounce with a window-based reference model.
// Edge counts are taken at falling edges after a stimulus change made at a falling edge.
module tb_dbg_switch_debounce;

  localparam int NUM_SW = 4;
  localparam int DEB    = 8;
  localparam int SYNC   = 2;

  logic              clk_25m = 1'b0;
  logic              rst_in  = 1'b1;
  logic [NUM_SW-1:0] sw_i    = '1;

  int n_checks = 0;
  int n_fails  = 0;
  bit mon_en   = 1'b0;

  always #20 clk_25m = ~clk_25m;

  dbg_switch_debounce_if #(.NUM_SW(NUM_SW)) sw_bus ();

  dbg_switch_debounce #(
    .NUM_SW         (NUM_SW),
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES    (SYNC),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk_25m(clk_25m),
    .rst_in (rst_in),
    .sw_i   (sw_i),
    .sw_if  (sw_bus.master)
  );

  // Reference model: the level flips once the last DEB synchronised samples,
  // all taken since the previous flip, disagree with it.
  logic [NUM_SW-1:0] m_level, m_press, m_release, m_toggle;
  logic              m_stable;
  logic              dline [NUM_SW][SYNC];
  logic              shist [NUM_SW][DEB];
  int                since_flip [NUM_SW];
  bit                busy_prev;
  bit                any_busy;
  bit                run_on;
  int                run;
  logic              s_now;

  always @(posedge clk_25m or posedge rst_in) begin
    if (rst_in) begin
      m_level   = '0;
      m_press   = '0;
      m_release = '0;
      m_toggle  = '0;
      m_stable  = 1'b1;
      busy_prev = 1'b0;
      for (int c = 0; c < NUM_SW; c++) begin
        since_flip[c] = 0;
        for (int k = 0; k < SYNC; k++) dline[c][k] = 1'b0;
        for (int k = 0; k < DEB; k++) shist[c][k] = 1'b0;
      end
    end else begin
      any_busy = 1'b0;
      for (int c = 0; c < NUM_SW; c++) begin
        m_toggle[c] = m_toggle[c] ^ m_press[c];
        s_now = dline[c][SYNC-1];
        for (int k = SYNC-1; k > 0; k--) dline[c][k] = dline[c][k-1];
        dline[c][0] = (sw_i[c] == 1'b0);
        for (int k = DEB-1; k > 0; k--) shist[c][k] = shist[c][k-1];
        shist[c][0] = s_now;
        if (since_flip[c] < 1000) since_flip[c]++;
        run    = 0;
        run_on = 1'b1;
        for (int k = 0; k < DEB; k++) begin
          if (run_on && k < since_flip[c] && shist[c][k] != m_level[c]) run++;
          else run_on = 1'b0;
        end
        m_press[c]   = 1'b0;
        m_release[c] = 1'b0;
        if (run == DEB) begin
          m_level[c]    = ~m_level[c];
          m_press[c]    = m_level[c];
          m_release[c]  = ~m_level[c];
          since_flip[c] = 0;
          run           = 0;
        end
        if (run != 0) any_busy = 1'b1;
      end
      m_stable  = ~busy_prev;
      busy_prev = any_busy;
    end
  end

  task automatic run_scoreboard();
    forever begin
      @(negedge clk_25m);
      if (mon_en) begin
        n_checks++;
        if (sw_bus.sw_level_o !== m_level || sw_bus.sw_press_p_o !== m_press ||
            sw_bus.sw_release_p_o !== m_release || sw_bus.sw_toggle_o !== m_toggle ||
            sw_bus.stable_o !== m_stable) begin
          n_fails++;
          $display("FAIL scoreboard t=%0t got lvl=%b prs=%b rel=%b tgl=%b stb=%b want lvl=%b prs=%b rel=%b tgl=%b stb=%b",
                   $time, sw_bus.sw_level_o, sw_bus.sw_press_p_o, sw_bus.sw_release_p_o,
                   sw_bus.sw_toggle_o, sw_bus.stable_o, m_level, m_press, m_release,
                   m_toggle, m_stable);
        end
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    sw_i = '1;
    @(negedge clk_25m); #2 rst_in = 1'b1;
    @(negedge clk_25m); #2 rst_in = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_25m); #1;
      if (sw_bus.sw_level_o !== 4'h0 || sw_bus.sw_press_p_o !== 4'h0 ||
          sw_bus.sw_release_p_o !== 4'h0 || sw_bus.sw_toggle_o !== 4'h0 ||
          sw_bus.stable_o !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fails++;
      $display("FAIL reset_idle: %0d non-idle cycles, required 0", bad);
    end
    $display("test_reset: idle 50 cycles, bad=%0d", bad);
  endtask

  task automatic test_clean_press();
    int first, cnt;
    @(negedge clk_25m); sw_i[0] = 1'b0;
    first = -1; cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_25m); #1;
      if (sw_bus.sw_press_p_o[0]) begin cnt++; if (first < 0) first = i; end
      if (i == 10) begin
        n_checks++;
        if (sw_bus.sw_toggle_o[0] !== 1'b0) begin
          n_fails++; $display("FAIL press_toggle_early: got %b required 0", sw_bus.sw_toggle_o[0]);
        end
      end
      if (i == 11) begin
        n_checks++;
        if (sw_bus.sw_toggle_o[0] !== 1'b1) begin
          n_fails++; $display("FAIL press_toggle: got %b required 1", sw_bus.sw_toggle_o[0]);
        end
      end
    end
    n_checks++;
    if (cnt != 1 || first != 10) begin
      n_fails++; $display("FAIL clean_press: pulses=%0d at=%0d required 1 at 10", cnt, first);
    end
    $display("test_clean_press: press pulses=%0d at edge %0d", cnt, first);
    @(negedge clk_25m); sw_i[0] = 1'b1;
    first = -1; cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_25m); #1;
      if (sw_bus.sw_release_p_o[0]) begin cnt++; if (first < 0) first = i; end
    end
    n_checks++;
    if (cnt != 1 || first != 10) begin
      n_fails++; $display("FAIL clean_release: pulses=%0d at=%0d required 1 at 10", cnt, first);
    end
    n_checks++;
    if (sw_bus.sw_toggle_o[0] !== 1'b1) begin
      n_fails++; $display("FAIL release_toggle: got %b required 1", sw_bus.sw_toggle_o[0]);
    end
    $display("test_clean_release: release pulses=%0d at edge %0d", cnt, first);
  endtask

  task automatic test_glitch();
    int cnt;
    @(negedge clk_25m); sw_i[1] = 1'b0;
    repeat (7) @(negedge clk_25m);
    sw_i[1] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_25m); #1;
      if (sw_bus.sw_press_p_o[1] || sw_bus.sw_level_o[1]) cnt++;
    end
    n_checks++;
    if (cnt != 0 || sw_bus.stable_o !== 1'b1) begin
      n_fails++; $display("FAIL glitch_7: events=%0d stable=%b required 0 and 1", cnt, sw_bus.stable_o);
    end
    $display("test_glitch: 7-cycle glitch events=%0d", cnt);
    sw_i[1] = 1'b0;
    repeat (9) @(negedge clk_25m);
    sw_i[1] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk_25m); #1;
      if (sw_bus.sw_press_p_o[1]) cnt++;
    end
    n_checks++;
    if (cnt != 1) begin
      n_fails++; $display("FAIL glitch_9: press pulses=%0d required 1", cnt);
    end
    $display("test_glitch: 9-cycle hold press pulses=%0d", cnt);
  endtask

  task automatic test_bounce();
    int first, cnt;
    cnt = 0; first = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_25m);
      if (i % 3 == 0) sw_i[2] = ~sw_i[2];
      #1 if (sw_bus.sw_press_p_o[2]) cnt++;
    end
    @(negedge clk_25m); sw_i[2] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_25m); #1;
      if (sw_bus.sw_press_p_o[2]) begin cnt++; if (first < 0) first = i; end
    end
    n_checks++;
    if (cnt != 1 || first != 10) begin
      n_fails++; $display("FAIL bounce: pulses=%0d at=%0d required 1 at 10", cnt, first);
    end
    $display("test_bounce: press pulses=%0d at edge %0d", cnt, first);
  endtask

  task automatic test_simultaneous();
    logic [NUM_SW-1:0] exp_tgl;
    bit seen;
    sw_i = '1;
    repeat (15) @(negedge clk_25m);
    exp_tgl = m_toggle ^ 4'hF;
    sw_i = 4'h0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_25m); #1;
      if (sw_bus.sw_press_p_o != 4'h0) begin
        seen = 1'b1;
        n_checks++;
        if (sw_bus.sw_press_p_o !== 4'hF) begin
          n_fails++; $display("FAIL simul_press: got %b required 1111", sw_bus.sw_press_p_o);
        end
        @(negedge clk_25m); #1;
        n_checks++;
        if (sw_bus.sw_toggle_o !== exp_tgl) begin
          n_fails++; $display("FAIL simul_toggle: got %b required %b", sw_bus.sw_toggle_o, exp_tgl);
        end
      end
    end
    n_checks++;
    if (!seen) begin
      n_fails++; $display("FAIL simul_timeout: no press pulse within 20 cycles");
    end
    $display("test_simultaneous: seen=%0d toggle=%b", seen, sw_bus.sw_toggle_o);
    sw_i = '1;
    repeat (15) @(negedge clk_25m);
  endtask

  task automatic test_random();
    int hold;
    for (int seg = 0; seg < 40; seg++) begin
      @(negedge clk_25m);
      sw_i = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 14);
      repeat (hold) @(negedge clk_25m);
      $display("test_random: seg=%0d sw=%b hold=%0d", seg, sw_i, hold);
    end
    sw_i = '1;
    repeat (20) @(negedge clk_25m);
  endtask

  task automatic test_reset_mid();
    int first, cnt;
    @(negedge clk_25m); sw_i[0] = 1'b0;
    repeat (6) @(negedge clk_25m);
    mon_en = 1'b0;
    #2 rst_in = 1'b1;
    #1;
    n_checks++;
    if (sw_bus.sw_level_o !== 4'h0 || sw_bus.sw_press_p_o !== 4'h0 ||
        sw_bus.sw_release_p_o !== 4'h0 || sw_bus.sw_toggle_o !== 4'h0 ||
        sw_bus.stable_o !== 1'b1) begin
      n_fails++;
      $display("FAIL reset_async: lvl=%b tgl=%b stb=%b required 0000 0000 1",
               sw_bus.sw_level_o, sw_bus.sw_toggle_o, sw_bus.stable_o);
    end
    @(negedge clk_25m); #2 rst_in = 1'b0;
    mon_en = 1'b1;
    first = -1; cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_25m); #1;
      if (sw_bus.sw_press_p_o[0]) begin cnt++; if (first < 0) first = i; end
    end
    n_checks++;
    if (cnt != 1 || first != 10) begin
      n_fails++; $display("FAIL reset_mid: pulses=%0d at=%0d required 1 at 10", cnt, first);
    end
    $display("test_reset_mid: press pulses=%0d at edge %0d", cnt, first);
  endtask

  initial begin
    fork
      run_scoreboard();
    join_none
    sw_i   = '1;
    rst_in = 1'b1;
    repeat (3) @(negedge clk_25m);
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_random();
    test_reset_mid();
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
